// File: rtl/mem_port_arbiter_if.sv
// Bundle of the request/response signals around mem_port_arbiter.
//
// Handshake rules:
//   Request side:  x_req is held with stable fields until x_gnt is seen high in
//                  the same cycle. x_gnt is high only when m_req and m_ready are
//                  both high in that cycle.
//   Response side: x_valid is a one-cycle pulse with x_rdata, with no back-pressure.
//   Memory side:   m_req/m_* are offered until m_ready is high in the same cycle.
//                  m_rvalid/m_rdata return the single outstanding response.
//
// Modports:
//   slave  : the arbiter's view. It takes requests and the memory responses, and
//            drives grants, responses and the memory request.
//   master : the environment's view (requesters plus memory). It is the mirror
//            image of slave.
interface mem_port_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_valid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wmask;
  logic        d_gnt;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wmask;
  logic        m_ready;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        bus_err;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wmask,
    input  m_ready, m_rvalid, m_rdata,
    output i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata,
    output m_req, m_we, m_addr, m_wdata, m_wmask, bus_err
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wmask,
    output m_ready, m_rvalid, m_rdata,
    input  i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata,
    input  m_req, m_we, m_addr, m_wdata, m_wmask, bus_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares a single memory port between instruction fetch (I) and load/store (D).
// Only one transaction is outstanding at a time.
//
// Arbitration:
//   - D normally wins.
//   - I is forced to win after FETCH_MAX_WAIT consecutive losses.
// Once a request is offered to memory, its owner is locked until the memory accepts it.
// A watchdog ends a WAIT state after TIMEOUT cycles:
//   - bus_err pulses.
//   - The owner receives a zero-data response.
//
// Ports:
//   clk, rst       : clock and synchronous active-high reset.
//   bus            : mem_port_arbiter_if.slave. Carries requester, memory and bus_err signals.
//   dbg_state      : current FSM state (0 IDLE, 1 ISSUE_I, 2 ISSUE_D, 3 WAIT_I, 4 WAIT_D).
//   dbg_starve_cnt : consecutive I arbitration losses.
module mem_port_arbiter #(
  parameter int unsigned FETCH_MAX_WAIT = 4,
  parameter int unsigned TIMEOUT        = 64
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus,
  output logic [2:0]          dbg_state,
  output logic [3:0]          dbg_starve_cnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE_I = 3'd1,
    ISSUE_D = 3'd2,
    WAIT_I  = 3'd3,
    WAIT_D  = 3'd4
  } state_t;

  localparam int unsigned      WD_W       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam bit               WD_EN      = (TIMEOUT > 0);
  localparam logic [WD_W-1:0]  WD_LAST    = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [3:0]       STARVE_MAX = 4'(FETCH_MAX_WAIT);

  state_t          state, state_nxt;
  logic [3:0]      starve_cnt;
  logic [WD_W-1:0] wd_cnt;
  logic            d_win, i_win, in_wait, wd_fire;

  // IDLE arbitration. The starvation override only matters while I is actually waiting.
  always_comb begin
    d_win   = bus.d_req && !(bus.i_req && (starve_cnt == STARVE_MAX));
    i_win   = bus.i_req && !d_win;
    in_wait = (state == WAIT_I) || (state == WAIT_D);
    // A real response arriving in the last watchdog cycle takes precedence.
    wd_fire = WD_EN && in_wait && (wd_cnt == WD_LAST) && !bus.m_rvalid;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (d_win)      state_nxt = bus.m_ready ? WAIT_D : ISSUE_D;
        else if (i_win) state_nxt = bus.m_ready ? WAIT_I : ISSUE_I;
      end
      ISSUE_I: if (bus.m_ready) state_nxt = WAIT_I;
      ISSUE_D: if (bus.m_ready) state_nxt = WAIT_D;
      WAIT_I, WAIT_D: if (bus.m_rvalid || wd_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic.
  // Everything stays quiet during reset so that an in-flight response is dropped.
  always_comb begin
    bus.i_gnt   = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_rdata = 32'h0;
    bus.d_gnt   = 1'b0;
    bus.d_valid = 1'b0;
    bus.d_rdata = 32'h0;
    bus.m_req   = 1'b0;
    bus.m_we    = 1'b0;
    bus.m_addr  = 32'h0;
    bus.m_wdata = 32'h0;
    bus.m_wmask = 4'h0;
    bus.bus_err = 1'b0;
    if (!rst) begin
      case (state)
        IDLE, ISSUE_I, ISSUE_D: begin
          if ((state == ISSUE_D) || ((state == IDLE) && d_win)) begin
            bus.m_req   = 1'b1;
            bus.m_we    = bus.d_we;
            bus.m_addr  = bus.d_addr;
            bus.m_wdata = bus.d_wdata;
            bus.m_wmask = bus.d_wmask;
            bus.d_gnt   = bus.m_ready;
          end else if ((state == ISSUE_I) || i_win) begin
            bus.m_req   = 1'b1;
            bus.m_addr  = bus.i_addr;
            bus.i_gnt   = bus.m_ready;
          end
        end
        WAIT_I: begin
          bus.i_valid = bus.m_rvalid || wd_fire;
          bus.i_rdata = bus.m_rvalid ? bus.m_rdata : 32'h0;
          bus.bus_err = wd_fire;
        end
        WAIT_D: begin
          bus.d_valid = bus.m_rvalid || wd_fire;
          bus.d_rdata = bus.m_rvalid ? bus.m_rdata : 32'h0;
          bus.bus_err = wd_fire;
        end
        default: ;
      endcase
    end
  end

  // Starvation counter. It only advances on IDLE losses while I is waiting.
  always_ff @(posedge clk) begin
    if (rst || bus.i_gnt)
      starve_cnt <= 4'h0;
    else if ((state == IDLE) && bus.i_req && d_win && (starve_cnt < STARVE_MAX))
      starve_cnt <= starve_cnt + 4'h1;
  end

  // Watchdog. It counts cycles spent in the current WAIT state.
  always_ff @(posedge clk) begin
    if (rst || !in_wait || (state_nxt != state)) wd_cnt <= '0;
    else                                          wd_cnt <= wd_cnt + 1'b1;
  end

  assign dbg_state      = state;
  assign dbg_starve_cnt = starve_cnt;

endmodule
